cbw_parser: RTL and testbench
=============================

// Module: cbw_parser
// PURPOSE
//  Receives USB Mass-Storage Bulk-Only Transport Command Block Wrappers (31 B) from the Bulk-Out AXI-S byte stream.
//  Validates the CBW and decodes tag, transfer length, direction, LUN and CDB for the SCSI controller.
//  Tag, length and direction also feed the status-wrapper transmitter.
//  Sits between the USB bulk-out endpoint and the SCSI command engine.
// PARAMETERS
//  MAX_LUN    0   highest LUN accepted; a larger bCBWLUN is invalid
// PORTS
//  clock            in   1    system clock
//  reset            in   1    asynchronous, active-low reset
//  enable_i         in   1    parser enable; low = abort, return to ST_IDLE, tready low
//  err_clr_i        in   1    Reset-Recovery done; leaves ST_ERROR
//  usb_tvalid_i     in   1    Bulk-Out stream valid
//  usb_tready_o     out  1    Bulk-Out stream ready
//  usb_tlast_i      in   1    last byte of USB transfer
//  usb_tdata_i      in   8    stream byte
//  cbw_vld_o        out  1    decoded CBW valid; held until cbw_rdy_i
//  cbw_rdy_i        in   1    SCSI controller accepts the CBW
//  cbw_dir_o        out  1    bmCBWFlags[7]; 1 = device-to-host
//  cbw_tag_o        out  32   dCBWTag
//  cbw_len_o        out  32   dCBWDataTransferLength
//  cbw_lun_o        out  4    bCBWLUN[3:0]
//  cbw_cdb_len_o    out  5    bCBWCBLength[4:0]
//  cbw_cdb_o        out  128  CBWCB; byte 15 of the CBW maps to [7:0]
//  cbw_err_o        out  1    invalid CBW; level, held in ST_ERROR
// BEHAVIOUR
//  - Reset: all outputs 0; state ST_IDLE; byte counter 0.
//  - Byte accepted on (usb_tvalid_i & usb_tready_o).
//  - usb_tready_o = enable_i & (state is ST_IDLE, ST_RECV or ST_DRAIN).
//  - All multi-byte fields are little-endian.
//  - Byte counter cnt (5 bit) selects the field:
//      0-3 signature; 4-7 tag; 8-11 length; 12 flags; 13 LUN;
//      14 CBLength; 15-30 CB bytes, written by index cnt-15.
//  - Fields capture directly into the output registers; outputs are valid only while cbw_vld_o=1.
//  - States:
//      ST_IDLE  : first accepted byte -> ST_RECV, cnt=1.
//      ST_RECV  : byte 30 with tlast -> ST_CHECK.
//                 tlast before byte 30 (short) -> ST_ERROR.
//                 byte 30 without tlast (long) -> ST_DRAIN.
//      ST_DRAIN : consume bytes until tlast, then -> ST_ERROR.
//      ST_CHECK : one cycle. Signature must be 32'h43425355.
//                 Also required: LUN<=MAX_LUN and 1<=CBLength<=16.
//                 Pass -> ST_VALID with cbw_vld_o=1 next cycle; fail -> ST_ERROR.
//      ST_VALID : cbw_vld_o held; on cbw_rdy_i -> ST_IDLE, cbw_vld_o=0 the same edge.
//      ST_ERROR : cbw_err_o=1; tready 0; err_clr_i -> ST_IDLE, err_clr_i has priority over enable.
//  - Latency: cbw_vld_o rises 2 cycles after the byte-30 handshake.
//  - No new CBW is accepted while cbw_vld_o=1; back-pressure is via tready=0.
//  - enable_i low mid-frame: discard, -> ST_IDLE next edge, no error, cbw_vld_o cleared.
//  - Async reset mid-frame: immediate return to reset state; partial CBW lost.
// CONFIGURATION
//  CBW_STRICT_CHECK_EN defined: ST_CHECK also rejects any of the following:
//    flags[6:0] nonzero; LUN[7:4] nonzero; CBLength[7:5] nonzero.
//  Not defined: reserved bits are ignored; only signature, LUN range and CBLength range are checked.
// STRUCTURE
//  - Shared package msc_pkg holds:
//      CBW_SIGNATURE=32'h43425355, CSW_SIGNATURE=32'h53425355;
//      CBW_LENGTH=31, CSW_LENGTH=13;
//      field byte offsets; state enum type.
//  - Single module; no sub-module (the field capture is a counter-indexed register write).
// TESTING
//  1. Valid CBW, tag 0xDEADBEEF, len 512, flags 0x80, LUN 0, CBLen 10, CDB 28 00..:
//     -> vld=1, dir=1, tag/len match, cdb[7:0]=0x28.
//  2. Signature 0x43425356, otherwise valid -> cbw_err_o=1, no vld.
//     err_clr_i pulse -> ST_IDLE, tready=1.
//  3. tlast on byte 20 -> ST_ERROR. 40-byte frame -> 31 bytes + 9 drained, then ST_ERROR.
//  4. cbw_rdy_i held 0 for 10 cycles -> vld stays 1, tready=0.
//     cbw_rdy_i=1 -> next CBW accepted.
//  5. enable_i dropped at byte 12 -> ST_IDLE, no err.
//     Next full valid CBW decodes correctly.
//  6. flags 0x81: with CBW_STRICT_CHECK_EN -> err; without -> vld, dir=1.

Source files
------------

// File: rtl/msc_pkg.sv
// Shared Mass-Storage Bulk-Only Transport constants: wrapper signatures, lengths,
// CBW field byte offsets and the CBW parser state type.
package msc_pkg;

    localparam logic [31:0] CBW_SIGNATURE = 32'h43425355;
    localparam logic [31:0] CSW_SIGNATURE = 32'h53425355;
    localparam int          CBW_LENGTH    = 31;
    localparam int          CSW_LENGTH    = 13;

    localparam logic [4:0] OFS_SIG   = 5'd0;
    localparam logic [4:0] OFS_TAG   = 5'd4;
    localparam logic [4:0] OFS_LEN   = 5'd8;
    localparam logic [4:0] OFS_FLAGS = 5'd12;
    localparam logic [4:0] OFS_LUN   = 5'd13;
    localparam logic [4:0] OFS_CBLEN = 5'd14;
    localparam logic [4:0] OFS_CB    = 5'd15;
    localparam logic [4:0] OFS_LAST  = 5'(CBW_LENGTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CHECK = 3'd3,
        ST_VALID = 3'd4,
        ST_ERROR = 3'd5
    } cbw_state_t;

endpackage

// File: rtl/cbw_parser.sv
// Bulk-Only Transport CBW receiver: captures the 31-byte wrapper, validates it, presents decoded fields.
// Define CBW_STRICT_CHECK_EN to also reject CBWs with nonzero reserved bits.
//
// state    | meaning
// ST_IDLE  | waiting for the first CBW byte
// ST_RECV  | capturing bytes 1..30
// ST_DRAIN | frame longer than 31 bytes, discarding up to tlast
// ST_CHECK | one-cycle validation of captured fields
// ST_VALID | decoded CBW presented, waiting for cbw_rdy_i
// ST_ERROR | invalid CBW, waiting for err_clr_i
module cbw_parser
    import msc_pkg::*;
#(
    parameter int MAX_LUN = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable_i,
    input  logic         err_clr_i,
    input  logic         usb_tvalid_i,
    output logic         usb_tready_o,
    input  logic         usb_tlast_i,
    input  logic [7:0]   usb_tdata_i,
    output logic         cbw_vld_o,
    input  logic         cbw_rdy_i,
    output logic         cbw_dir_o,
    output logic [31:0]  cbw_tag_o,
    output logic [31:0]  cbw_len_o,
    output logic [3:0]   cbw_lun_o,
    output logic [4:0]   cbw_cdb_len_o,
    output logic [127:0] cbw_cdb_o,
    output logic         cbw_err_o
);

    localparam logic [3:0] MAX_LUN_V = 4'(MAX_LUN);

    cbw_state_t  state, state_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic [31:0] sig_q;
    logic [3:0]  cb_idx;
    logic        accept;
    logic        fields_ok;
    logic        rsv_ok;

`ifdef CBW_STRICT_CHECK_EN
    logic [6:0] flags_rsv;
    logic [3:0] lun_rsv;
    logic [2:0] cblen_rsv;
`endif

    assign usb_tready_o = enable_i &
                          ((state == ST_IDLE) | (state == ST_RECV) | (state == ST_DRAIN));
    assign accept       = usb_tvalid_i & usb_tready_o;
    assign cbw_vld_o    = (state == ST_VALID);
    assign cbw_err_o    = (state == ST_ERROR);
    assign cb_idx       = 4'(cnt - OFS_CB);

`ifdef CBW_STRICT_CHECK_EN
    assign rsv_ok = (flags_rsv == 7'd0) && (lun_rsv == 4'd0) && (cblen_rsv == 3'd0);
`else
    assign rsv_ok = 1'b1;
`endif

    assign fields_ok = (sig_q == CBW_SIGNATURE) &&
                       (cbw_lun_o <= MAX_LUN_V) &&
                       (cbw_cdb_len_o != 5'd0) && (cbw_cdb_len_o <= 5'd16) &&
                       rsv_ok;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == ST_ERROR) begin
            if (err_clr_i) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        end else if (!enable_i) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (usb_tlast_i) begin
                            state_nxt = ST_ERROR;
                        end else begin
                            state_nxt = ST_RECV;
                            cnt_nxt   = 5'd1;
                        end
                    end
                end
                ST_RECV: begin
                    if (accept) begin
                        if (cnt == OFS_LAST) begin
                            state_nxt = usb_tlast_i ? ST_CHECK : ST_DRAIN;
                            cnt_nxt   = '0;
                        end else if (usb_tlast_i) begin
                            state_nxt = ST_ERROR;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 5'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept && usb_tlast_i) state_nxt = ST_ERROR;
                end
                ST_CHECK: state_nxt = fields_ok ? ST_VALID : ST_ERROR;
                ST_VALID: begin
                    if (cbw_rdy_i) state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Bytes land straight in the output registers, indexed by the byte counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sig_q         <= '0;
            cbw_tag_o     <= '0;
            cbw_len_o     <= '0;
            cbw_dir_o     <= 1'b0;
            cbw_lun_o     <= '0;
            cbw_cdb_len_o <= '0;
            cbw_cdb_o     <= '0;
`ifdef CBW_STRICT_CHECK_EN
            flags_rsv     <= '0;
            lun_rsv       <= '0;
            cblen_rsv     <= '0;
`endif
        end else if (accept && (state != ST_DRAIN)) begin
            if (cnt < OFS_TAG) begin
                sig_q[{cnt[1:0], 3'b000} +: 8] <= usb_tdata_i;
            end else if (cnt < OFS_LEN) begin
                cbw_tag_o[{cnt[1:0], 3'b000} +: 8] <= usb_tdata_i;
            end else if (cnt < OFS_FLAGS) begin
                cbw_len_o[{cnt[1:0], 3'b000} +: 8] <= usb_tdata_i;
            end else if (cnt == OFS_FLAGS) begin
                cbw_dir_o <= usb_tdata_i[7];
`ifdef CBW_STRICT_CHECK_EN
                flags_rsv <= usb_tdata_i[6:0];
`endif
            end else if (cnt == OFS_LUN) begin
                cbw_lun_o <= usb_tdata_i[3:0];
`ifdef CBW_STRICT_CHECK_EN
                lun_rsv   <= usb_tdata_i[7:4];
`endif
            end else if (cnt == OFS_CBLEN) begin
                cbw_cdb_len_o <= usb_tdata_i[4:0];
`ifdef CBW_STRICT_CHECK_EN
                cblen_rsv     <= usb_tdata_i[7:5];
`endif
            end else begin
                cbw_cdb_o[{cb_idx, 3'b000} +: 8] <= usb_tdata_i;
            end
        end
    end

endmodule

// File: tb/tb_cbw_parser.sv
// Directed self-checking bench for cbw_parser: valid decode, bad signature, short/long frames,
// back-pressure, enable abort, LUN/CBLength boundaries and reserved flag bits.
module tb_cbw_parser;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic         err_clr;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic [7:0]   tdata;
    logic         vld;
    logic         rdy;
    logic         dir;
    logic [31:0]  tag;
    logic [31:0]  len;
    logic [3:0]   lun;
    logic [4:0]   cdb_len;
    logic [127:0] cdb;
    logic         err;

    int checks = 0;
    int errors = 0;
    logic [7:0] fr [0:39];

    cbw_parser #(.MAX_LUN(0)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable_i      (enable),
        .err_clr_i     (err_clr),
        .usb_tvalid_i  (tvalid),
        .usb_tready_o  (tready),
        .usb_tlast_i   (tlast),
        .usb_tdata_i   (tdata),
        .cbw_vld_o     (vld),
        .cbw_rdy_i     (rdy),
        .cbw_dir_o     (dir),
        .cbw_tag_o     (tag),
        .cbw_len_o     (len),
        .cbw_lun_o     (lun),
        .cbw_cdb_len_o (cdb_len),
        .cbw_cdb_o     (cdb),
        .cbw_err_o     (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // CDB bytes: 0x28 first, then 0x11..0x1F, then filler for oversize frames.
    task automatic build(input logic [31:0] sig, input logic [31:0] t, input logic [31:0] l,
                         input logic [7:0] flags, input logic [7:0] lun_b, input logic [7:0] cblen);
        for (int i = 0; i < 4; i++) begin
            fr[i]     = sig[8*i +: 8];
            fr[4 + i] = t[8*i +: 8];
            fr[8 + i] = l[8*i +: 8];
        end
        fr[12] = flags;
        fr[13] = lun_b;
        fr[14] = cblen;
        fr[15] = 8'h28;
        for (int i = 16; i < 40; i++) fr[i] = 8'h10 + 8'(i - 15);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        bit done = 1'b0;
        @(negedge clock);
        tvalid = 1'b1;
        tdata  = b;
        tlast  = last;
        for (int k = 0; k < 40 && !done; k++) begin
            if (tready) begin
                @(posedge clock);
                done = 1'b1;
            end else begin
                @(negedge clock);
            end
        end
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        chk("handshake", done, 1);
    endtask

    task automatic send_range(input int first, input int last_idx, input int tlast_at);
        for (int i = first; i <= last_idx; i++) send_byte(fr[i], i == tlast_at);
    endtask

    task automatic release_cbw();
        @(negedge clock);
        rdy = 1'b1;
        @(negedge clock);
        rdy = 1'b0;
        chk("release_vld", vld, 0);
        chk("release_tready", tready, 1);
    endtask

    task automatic clear_err();
        @(negedge clock);
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        chk("clr_err", err, 0);
        chk("clr_tready", tready, 1);
    endtask

    task automatic full_frame();
        send_range(0, 30, 30);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        reset   = 1'b0;
        enable  = 1'b0;
        err_clr = 1'b0;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        tdata   = 8'h00;
        rdy     = 1'b0;
        #23;
        chk("rst_vld", vld, 0);
        chk("rst_err", err, 0);
        chk("rst_tready", tready, 0);
        chk("rst_tag", tag, 0);
        chk("rst_cdb", cdb, 0);
        @(negedge clock);
        reset  = 1'b1;
        enable = 1'b1;
        #1;
        chk("idle_tready", tready, 1);

        // Valid CBW with latency check, then back-pressure hold
        build(32'h43425355, 32'hDEADBEEF, 32'd512, 8'h80, 8'h00, 8'd10);
        send_range(0, 30, 30);
        @(negedge clock);
        chk("lat_vld_early", vld, 0);
        @(negedge clock);
        chk("t1_vld", vld, 1);
        chk("t1_dir", dir, 1);
        chk("t1_tag", tag, 32'hDEADBEEF);
        chk("t1_len", len, 32'd512);
        chk("t1_lun", lun, 0);
        chk("t1_cdb_len", cdb_len, 10);
        chk("t1_cdb0", cdb[7:0], 8'h28);
        chk("t1_cdb", cdb, 128'h1F1E1D1C_1B1A1918_17161514_13121128);
        chk("t1_err", err, 0);
        repeat (10) @(negedge clock);
        chk("hold_vld", vld, 1);
        chk("hold_tready", tready, 0);
        release_cbw();

        // CBLength 16 upper bound accepted right after release
        build(32'h43425355, 32'h00000001, 32'd0, 8'h00, 8'h00, 8'd16);
        full_frame();
        chk("cbl16_vld", vld, 1);
        chk("cbl16_len", cdb_len, 16);
        chk("cbl16_tag", tag, 32'h00000001);
        release_cbw();

        // Bad signature; enable low in ERROR must not clear it
        build(32'h43425356, 32'hDEADBEEF, 32'd512, 8'h80, 8'h00, 8'd10);
        full_frame();
        chk("badsig_err", err, 1);
        chk("badsig_vld", vld, 0);
        chk("badsig_tready", tready, 0);
        enable = 1'b0;
        @(negedge clock);
        chk("err_hold_no_en", err, 1);
        enable = 1'b1;
        clear_err();

        build(32'h43425355, 32'h0, 32'd0, 8'h00, 8'h01, 8'd10);
        full_frame();
        chk("lun1_err", err, 1);
        clear_err();

        build(32'h43425355, 32'h0, 32'd0, 8'h00, 8'h00, 8'd0);
        full_frame();
        chk("cbl0_err", err, 1);
        clear_err();

        build(32'h43425355, 32'h0, 32'd0, 8'h00, 8'h00, 8'd17);
        full_frame();
        chk("cbl17_err", err, 1);
        clear_err();

        // Short frame: tlast on byte 20
        build(32'h43425355, 32'hDEADBEEF, 32'd512, 8'h80, 8'h00, 8'd10);
        send_range(0, 20, 20);
        @(negedge clock);
        chk("short_err", err, 1);
        chk("short_vld", vld, 0);
        clear_err();

        // Long frame: 40 bytes, 9 drained
        send_range(0, 30, -1);
        @(negedge clock);
        chk("long_drain_err", err, 0);
        chk("long_drain_tready", tready, 1);
        send_range(31, 39, 39);
        @(negedge clock);
        chk("long_err", err, 1);
        clear_err();

        // Enable dropped after byte 11, then a fresh CBW
        send_range(0, 11, -1);
        @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        chk("abort_err", err, 0);
        chk("abort_vld", vld, 0);
        chk("abort_tready", tready, 0);
        enable = 1'b1;
        build(32'h43425355, 32'h12345678, 32'h00001000, 8'h00, 8'h00, 8'd6);
        full_frame();
        chk("t5_vld", vld, 1);
        chk("t5_tag", tag, 32'h12345678);
        chk("t5_len", len, 32'h00001000);
        chk("t5_dir", dir, 0);
        chk("t5_cdb_len", cdb_len, 6);
        release_cbw();

        // Reserved flag bit
        build(32'h43425355, 32'hCAFEF00D, 32'd64, 8'h81, 8'h00, 8'd10);
        full_frame();
`ifdef CBW_STRICT_CHECK_EN
        chk("f81_err", err, 1);
        chk("f81_vld", vld, 0);
        clear_err();
`else
        chk("f81_vld", vld, 1);
        chk("f81_dir", dir, 1);
        chk("f81_tag", tag, 32'hCAFEF00D);
        release_cbw();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
